// File: rtl/sata_phy_rx_prim.sv
// SATA PHY receive primitive decoder: classifies GTP dwords into data,
// primitives, ALIGN and CONT, with CONT repeat tracking and error flagging.
module sata_phy_rx_prim (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        phy_links_up_in,
  input  logic [31:0] gt_rxdata_in,
  input  logic [3:0]  gt_rxcharisk_in,
  output logic [31:0] rx_data_out,
  output logic        rx_data_valid_out,
  output logic [3:0]  rx_prim_out,
  output logic        rx_prim_valid_out,
  output logic        rx_cont_active_out,
  output logic        rx_err_out,
  output logic [15:0] rx_align_cnt_out
);

  localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
  localparam logic [31:0] CONT_DW  = 32'h9999AA7C;
  localparam logic [3:0]  ILLEGAL  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORMAL,
    S_CONT
  } state_t;

  state_t      r_state;
  logic [3:0]  r_last;
  logic [31:0] r_data;
  logic        r_dv;
  logic [3:0]  r_prim;
  logic        r_pv;
  logic        r_err;
  logic [15:0] r_cnt;

  logic        w_is_k;
  logic        w_is_data;
  logic        w_is_align;
  logic        w_is_cont;
  logic        w_known;
  logic [3:0]  w_code;

  function automatic logic [3:0] prim_code(input logic [31:0] d);
    case (d)
      32'hB5B5957C: prim_code = 4'd1;
      32'h5757B57C: prim_code = 4'd2;
      32'h4A4A957C: prim_code = 4'd3;
      32'h3737B57C: prim_code = 4'd4;
      32'hD5D5B57C: prim_code = 4'd5;
      32'hD5D5AA7C: prim_code = 4'd6;
      32'h9595AA7C: prim_code = 4'd7;
      32'h5555B57C: prim_code = 4'd8;
      32'h3535B57C: prim_code = 4'd9;
      32'h5656B57C: prim_code = 4'd10;
      32'h5858B57C: prim_code = 4'd11;
      32'h3636B57C: prim_code = 4'd12;
      default:      prim_code = 4'd0;
    endcase
  endfunction

  always_comb begin
    w_is_k     = (gt_rxcharisk_in == 4'b0001);
    w_is_data  = (gt_rxcharisk_in == 4'b0000);
    w_code     = prim_code(gt_rxdata_in);
    w_is_align = w_is_k && (gt_rxdata_in == ALIGN_DW);
    w_is_cont  = w_is_k && (gt_rxdata_in == CONT_DW);
    w_known    = w_is_k && (w_code != 4'd0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
      r_last  <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_prim  <= '0;
      r_pv    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_dv   <= 1'b0;
      r_pv   <= 1'b0;
      r_prim <= '0;
      r_err  <= 1'b0;
      if (!phy_links_up_in) begin
        r_state <= S_IDLE;
        r_last  <= '0;
        r_cnt   <= '0;
        r_data  <= '0;
      end else if (r_state == S_IDLE) begin
        r_state <= S_NORMAL;
      end else begin
        unique case (1'b1)
          w_is_align: begin
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
          end
          w_is_data: begin
            // Scrambled filler during a CONT repeat is not payload
            if (r_state == S_NORMAL) begin
              r_data <= gt_rxdata_in;
              r_dv   <= 1'b1;
            end else begin
              r_prim <= r_last;
              r_pv   <= 1'b1;
            end
          end
          w_is_cont: begin
            if (r_last != 4'd0) begin
              r_state <= S_CONT;
              r_prim  <= r_last;
              r_pv    <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          w_known: begin
            r_state <= S_NORMAL;
            r_prim  <= w_code;
            r_pv    <= 1'b1;
            r_last  <= w_code;
          end
          default: begin
            r_state <= S_NORMAL;
            r_err   <= 1'b1;
            r_prim  <= ILLEGAL;
            r_pv    <= 1'b1;
            r_last  <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data_out        = r_data;
  assign rx_data_valid_out  = r_dv;
  assign rx_prim_out        = r_prim;
  assign rx_prim_valid_out  = r_pv;
  assign rx_cont_active_out = (r_state == S_CONT);
  assign rx_err_out         = r_err;
  assign rx_align_cnt_out   = r_cnt;

endmodule

// File: tb/tb_sata_phy_rx_prim.sv
// Directed bench for sata_phy_rx_prim with immediate-assertion checks.
// Every expected value below is hand-derived from the primitive table.
module tb_sata_phy_rx_prim;

  localparam logic [31:0] SYNC  = 32'hB5B5957C;
  localparam logic [31:0] XRDY  = 32'h5757B57C;
  localparam logic [31:0] SOF   = 32'h3737B57C;
  localparam logic [31:0] EOF   = 32'hD5D5B57C;
  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] CONT  = 32'h9999AA7C;

  logic        clk;
  logic        rst_n;
  logic        link;
  logic [31:0] din;
  logic [3:0]  kin;
  logic [31:0] dout;
  logic        dv;
  logic [3:0]  prim;
  logic        pv;
  logic        ca;
  logic        err;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  sata_phy_rx_prim dut (
    .sys_clk            (clk),
    .sys_rst            (rst_n),
    .phy_links_up_in    (link),
    .gt_rxdata_in       (din),
    .gt_rxcharisk_in    (kin),
    .rx_data_out        (dout),
    .rx_data_valid_out  (dv),
    .rx_prim_out        (prim),
    .rx_prim_valid_out  (pv),
    .rx_cont_active_out (ca),
    .rx_err_out         (err),
    .rx_align_cnt_out   (cnt)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic outs(input string tag, input logic e_dv,
                      input logic [31:0] e_d, input logic e_pv,
                      input logic [3:0] e_p, input logic e_ca,
                      input logic e_err, input logic [15:0] e_cnt);
    chk({tag, ".dv"},   {31'd0, dv},  {31'd0, e_dv});
    chk({tag, ".data"}, dout,         e_d);
    chk({tag, ".pv"},   {31'd0, pv},  {31'd0, e_pv});
    chk({tag, ".prim"}, {28'd0, prim}, {28'd0, e_p});
    chk({tag, ".ca"},   {31'd0, ca},  {31'd0, e_ca});
    chk({tag, ".err"},  {31'd0, err}, {31'd0, e_err});
    chk({tag, ".cnt"},  {16'd0, cnt}, {16'd0, e_cnt});
  endtask

  task automatic step(input logic l, input logic [3:0] k,
                      input logic [31:0] d);
    link = l;
    kin  = k;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    link  = 1'b0;
    din   = '0;
    kin   = '0;
    #10;
    outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 4'b0000, 32'h0);
    outs("idle", 0, 0, 0, 0, 0, 0, 0);

    // link up: first cycle only leaves IDLE
    step(1, 4'b0000, 32'hFFFF0000);
    outs("linkup", 0, 0, 0, 0, 0, 0, 0);
    step(1, 4'b0001, ALIGN);
    outs("align1", 0, 0, 0, 0, 0, 0, 1);
    step(1, 4'b0001, ALIGN);
    outs("align2", 0, 0, 0, 0, 0, 0, 2);
    step(1, 4'b0001, SYNC);
    outs("sync", 0, 0, 1, 1, 0, 0, 2);

    // X_RDY, CONT, junk x3, ALIGN, SOF
    step(1, 4'b0001, XRDY);
    outs("xrdy", 0, 0, 1, 2, 0, 0, 2);
    step(1, 4'b0001, CONT);
    outs("cont", 0, 0, 1, 2, 1, 0, 2);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0000, 32'h12345678);
      outs("junk", 0, 0, 1, 2, 1, 0, 2);
    end
    step(1, 4'b0001, ALIGN);
    outs("cont_align", 0, 0, 0, 0, 1, 0, 3);
    step(1, 4'b0001, SOF);
    outs("sof_exit", 0, 0, 1, 4, 0, 0, 3);

    // data frame
    step(1, 4'b0000, 32'hCAFEBABE);
    outs("data0", 1, 32'hCAFEBABE, 0, 0, 0, 0, 3);
    step(1, 4'b0000, 32'h00000001);
    outs("data1", 1, 32'h00000001, 0, 0, 0, 0, 3);
    step(1, 4'b0001, EOF);
    outs("eof", 0, 32'h00000001, 1, 5, 0, 0, 3);

    // link drop clears everything, then CONT with no history
    step(0, 4'b0000, 32'h0);
    outs("drop", 0, 0, 0, 0, 0, 0, 0);
    step(1, 4'b0000, 32'h0);
    outs("relink", 0, 0, 0, 0, 0, 0, 0);
    step(1, 4'b0001, CONT);
    outs("cont_err", 0, 0, 0, 0, 0, 1, 0);
    step(1, 4'b0011, SYNC);
    outs("k0011", 0, 0, 1, 15, 0, 1, 0);
    step(1, 4'b0001, 32'h1234567C);
    outs("badk", 0, 0, 1, 15, 0, 1, 0);
    step(1, 4'b0001, CONT);
    outs("cont_after_bad", 0, 0, 0, 0, 0, 1, 0);

    // drop link mid CONT_ACTIVE
    step(1, 4'b0001, SYNC);
    outs("sync2", 0, 0, 1, 1, 0, 0, 0);
    step(1, 4'b0001, ALIGN);
    outs("align3", 0, 0, 0, 0, 0, 0, 1);
    step(1, 4'b0001, CONT);
    outs("cont2", 0, 0, 1, 1, 1, 0, 1);
    step(0, 4'b0001, CONT);
    outs("drop_cont", 0, 0, 0, 0, 0, 0, 0);

    // async reset mid-stream
    step(1, 4'b0000, 32'h0);
    step(1, 4'b0001, ALIGN);
    step(1, 4'b0000, 32'hDEADBEEF);
    step(1, 4'b0001, SOF);
    outs("pre_rst", 0, 32'hDEADBEEF, 1, 4, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALIGN counter saturation
    step(1, 4'b0000, 32'h0);
    for (int i = 0; i < 65534; i++) step(1, 4'b0001, ALIGN);
    outs("cnt_fffe", 0, 0, 0, 0, 0, 0, 16'hFFFE);
    step(1, 4'b0001, ALIGN);
    outs("cnt_ffff", 0, 0, 0, 0, 0, 0, 16'hFFFF);
    for (int i = 0; i < 70000 - 65535; i++) step(1, 4'b0001, ALIGN);
    outs("cnt_sat", 0, 0, 0, 0, 0, 0, 16'hFFFF);
    step(1, 4'b0001, SYNC);
    outs("post_sat", 0, 0, 1, 1, 0, 0, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
